// File: rtl/mutation_engine_if.sv
// Handshake bundle between crossover, the mutation engine and
// fitness evaluation.
interface mutation_engine_if #(
  parameter int GENE_W    = 8,
  parameter int NUM_GENES = 4
);
  localparam int CHROM_W = GENE_W * NUM_GENES;
  localparam int CW      = $clog2(NUM_GENES + 1);

  logic               in_valid;
  logic               in_ready;
  logic [CHROM_W-1:0] crossover_gene;
  logic [7:0]         mutation_rate;
  logic               seed_load;
  logic [31:0]        seed;
  logic               out_valid;
  logic               out_ready;
  logic [CHROM_W-1:0] mutated_gene;
  logic [CW-1:0]      mutation_count;
  logic [15:0]        total_mutations;

  modport master (
    output in_valid, crossover_gene, mutation_rate,
    output seed_load, seed, out_ready,
    input  in_ready, out_valid, mutated_gene,
    input  mutation_count, total_mutations
  );

  modport slave (
    input  in_valid, crossover_gene, mutation_rate,
    input  seed_load, seed, out_ready,
    output in_ready, out_valid, mutated_gene,
    output mutation_count, total_mutations
  );
endinterface

// File: rtl/mutation_engine.sv
// GA mutation stage: walks one gene per cycle and flips an
// LFSR-chosen bit when the LFSR roll is below the rate.
module mutation_engine #(
  parameter int          GENE_W    = 8,
  parameter int          NUM_GENES = 4,
  parameter logic [31:0] LFSR_SEED = 32'hACE12357
) (
  input logic              clk,
  input logic              rst,
  mutation_engine_if.slave bus
);
  localparam int CHROM_W = GENE_W * NUM_GENES;
  localparam int CW = $clog2(NUM_GENES + 1);
  localparam int BW = $clog2(GENE_W);
  localparam int IW =
    (NUM_GENES > 1) ? $clog2(NUM_GENES) : 1;
  localparam logic [31:0] MASK = 32'h80200003;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUTATE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [CHROM_W-1:0] work_q, work_d;
  logic [CHROM_W-1:0] mut_q, mut_d;
  logic [7:0]         rate_q, rate_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        tot_q, tot_d;

  logic [7:0]         roll;
  logic [BW-1:0]      bitsel;
  logic [GENE_W-1:0]  flip;
  logic               hit;
  logic               accept;

  function automatic logic [31:0] lfsr_next(
    input logic [31:0] l
  );
    return l[0] ? ((l >> 1) ^ MASK) : (l >> 1);
  endfunction

  assign roll   = lfsr_q[7:0];
  assign bitsel = lfsr_q[8 +: BW];
  assign flip   = GENE_W'(1) << bitsel;
  assign hit    = roll < rate_q;

  // Ready is masked by reset so nothing is offered mid-reset.
  assign bus.in_ready = rst && (state_q == S_IDLE)
                        && !bus.seed_load;
  assign accept = bus.in_valid && bus.in_ready;

  assign bus.out_valid       = (state_q == S_DONE);
  assign bus.mutated_gene    = mut_q;
  assign bus.mutation_count  = cnt_q;
  assign bus.total_mutations = tot_q;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    work_d  = work_q;
    mut_d   = mut_q;
    rate_d  = rate_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tot_d   = tot_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.seed_load) begin
          lfsr_d = (bus.seed == 32'd0) ? LFSR_SEED
                                       : bus.seed;
        end else if (accept) begin
          work_d  = bus.crossover_gene;
          rate_d  = bus.mutation_rate;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_MUTATE;
        end
      end
      S_MUTATE: begin
        lfsr_d = lfsr_next(lfsr_q);
        if (hit) begin
          for (int g = 0; g < NUM_GENES; g++) begin
            if (int'(idx_q) == g) begin
              work_d[g*GENE_W +: GENE_W] =
                work_q[g*GENE_W +: GENE_W] ^ flip;
            end
          end
          cnt_d = cnt_q + CW'(1);
          if (tot_q != 16'hFFFF) begin
            tot_d = tot_q + 16'd1;
          end
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NUM_GENES - 1)) begin
          mut_d   = work_d;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      work_q  <= '0;
      mut_q   <= '0;
      rate_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tot_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      work_q  <= work_d;
      mut_q   <= mut_d;
      rate_q  <= rate_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tot_q   <= tot_d;
    end
  end
endmodule

// File: tb/tb_mutation_engine.sv
// Randomised bench for mutation_engine against a per-pass
// reference model; a wide second instance exercises saturation.
module tb_mutation_engine;
  localparam logic [31:0] SEED = 32'hACE12357;
  localparam logic [31:0] MASK = 32'h80200003;

  logic clk;
  logic rst;
  logic rst_s;
  int   n_chk;
  int   n_fail;

  logic [31:0] m_lfsr;
  int          m_total;

  mutation_engine_if #(.GENE_W(8), .NUM_GENES(4)) bus ();
  mutation_engine_if #(.GENE_W(2), .NUM_GENES(64)) sbus ();

  mutation_engine #(
    .GENE_W(8), .NUM_GENES(4), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  mutation_engine #(
    .GENE_W(2), .NUM_GENES(64), .LFSR_SEED(SEED)
  ) dut_sat (
    .clk(clk), .rst(rst_s), .bus(sbus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ MASK) : (l >> 1);
  endfunction

  task automatic model_pass(input logic [31:0] gene,
                            input logic [7:0] rate,
                            output logic [31:0] res,
                            output int cnt);
    int pos;
    res = gene;
    cnt = 0;
    for (int g = 0; g < 4; g++) begin
      if (m_lfsr[7:0] < rate) begin
        pos = g * 8 + int'(m_lfsr[10:8]);
        res[pos] = ~res[pos];
        cnt++;
        if (m_total < 65535) m_total++;
      end
      m_lfsr = nxt(m_lfsr);
    end
  endtask

  task automatic do_seed(input logic [31:0] s);
    bus.seed_load = 1'b1;
    bus.seed = s;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    m_lfsr = (s == 32'd0) ? SEED : s;
  endtask

  task automatic run_pass(input logic [31:0] gene,
                          input logic [7:0] rate,
                          input int stall,
                          output logic [31:0] got,
                          output int got_cnt);
    logic [31:0] exp;
    int ecnt;
    int lat;
    bit seen;
    got = '0;
    got_cnt = 0;
    bus.in_valid = 1'b1;
    bus.crossover_gene = gene;
    bus.mutation_rate = rate;
    bus.out_ready = (stall == 0);
    #1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.in_ready) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("accept_rdy", 64'(seen), 64'd1);
    if (!seen) begin
      bus.in_valid = 1'b0;
      return;
    end
    model_pass(gene, rate, exp, ecnt);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.crossover_gene = $urandom;
    bus.mutation_rate = 8'($urandom);
    chk("busy_rdy", 64'(bus.in_ready), 64'd0);
    lat = 1;
    while (lat <= 20) begin
      @(posedge clk); #1;
      if (bus.out_valid) break;
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    if (lat > 20) return;
    got = bus.mutated_gene;
    got_cnt = int'(bus.mutation_count);
    chk("result", 64'(got), 64'(exp));
    chk("mcount", 64'(got_cnt), 64'(ecnt));
    chk("total", 64'(bus.total_mutations), 64'(m_total));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_vld", 64'(bus.out_valid), 64'd1);
      chk("stall_dat", 64'(bus.mutated_gene), 64'(got));
      chk("stall_rdy", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_vld", 64'(bus.out_valid), 64'd0);
    chk("drain_rdy", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic main_seq();
    logic [31:0] r, r3, r3b, r4, rb_gene;
    logic [31:0] diff;
    logic [7:0]  rb_rate;
    int c, nz, pc, t0;
    bit seen;

    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.crossover_gene = '0;
    bus.mutation_rate = '0;
    bus.seed_load = 1'b0;
    bus.seed = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_vld", 64'(bus.out_valid), 64'd0);
      chk("rst_rdy", 64'(bus.in_ready), 64'd0);
      chk("rst_dat", 64'(bus.mutated_gene), 64'd0);
      chk("rst_tot", 64'(bus.total_mutations), 64'd0);
    end
    rst = 1'b1;
    m_lfsr = SEED;
    m_total = 0;
    #1;
    chk("rel_rdy", 64'(bus.in_ready), 64'd1);

    do_seed(32'd1);
    run_pass(32'h04030201, 8'd0, 0, r, c);
    chk("rate0_dat", 64'(r), 64'h04030201);
    chk("rate0_cnt", 64'(c), 64'd0);
    chk("rate0_tot", 64'(bus.total_mutations), 64'd0);

    do_seed(32'h12345678);
    t0 = int'(bus.total_mutations);
    run_pass(32'h08070605, 8'd255, 0, r3, c);
    diff = r3 ^ 32'h08070605;
    nz = 0;
    for (int b = 0; b < 4; b++) begin
      pc = $countones(diff[b*8 +: 8]);
      chk("byte_pc", 64'(pc <= 1), 64'd1);
      if (pc != 0) nz++;
    end
    chk("cnt_nz", 64'(c), 64'(nz));
    chk("tot_delta", 64'(bus.total_mutations),
        64'(t0 + nz));
    rb_gene = $urandom;
    rb_rate = 8'($urandom_range(64, 255));
    run_pass(rb_gene, rb_rate, 0, r3b, c);

    do_seed(32'h12345678);
    run_pass(32'h08070605, 8'd255, 10, r4, c);
    chk("stall_same", 64'(r4), 64'(r3));
    run_pass(rb_gene, rb_rate, 0, r4, c);
    chk("stall_next", 64'(r4), 64'(r3b));

    do_seed(32'd0);
    run_pass($urandom, 8'd128, 0, r, c);
    bus.seed_load = 1'b1;
    bus.seed = 32'hDEADBEEF;
    bus.in_valid = 1'b1;
    bus.crossover_gene = $urandom;
    #1;
    chk("seedld_rdy", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    m_lfsr = 32'hDEADBEEF;
    #1;
    chk("seedld_noacc", 64'(bus.in_ready), 64'd1);
    run_pass(bus.crossover_gene, 8'd200, 0, r, c);
    for (int i = 0; i < 4; i++) begin
      run_pass($urandom, 8'($urandom), 0, r, c);
    end

    bus.in_valid = 1'b1;
    bus.crossover_gene = $urandom;
    bus.mutation_rate = 8'd255;
    bus.out_ready = 1'b1;
    #1;
    chk("r6_rdy", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_lfsr = SEED;
    m_total = 0;
    #1;
    chk("r6_rdy_after", 64'(bus.in_ready), 64'd1);
    chk("r6_vld_after", 64'(bus.out_valid), 64'd0);
    chk("r6_tot", 64'(bus.total_mutations), 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    chk("r6_no_vld", 64'(seen), 64'd0);
    run_pass($urandom, 8'd180, 0, r, c);
  endtask

  task automatic sat_seq();
    logic [31:0] sl;
    int raw, cnt, w;
    rst_s = 1'b0;
    sbus.in_valid = 1'b0;
    sbus.crossover_gene = '0;
    sbus.mutation_rate = 8'd255;
    sbus.seed_load = 1'b0;
    sbus.seed = '0;
    sbus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_s = 1'b1;
    sbus.in_valid = 1'b1;
    sbus.crossover_gene = {4{$urandom}};
    sl = SEED;
    raw = 0;
    while (raw < 70000) begin
      w = 0;
      while (w < 100) begin
        @(posedge clk); #1;
        if (sbus.out_valid) break;
        w++;
      end
      if (w >= 100) begin
        chk("sat_timeout", 64'd0, 64'd1);
        break;
      end
      cnt = 0;
      for (int g = 0; g < 64; g++) begin
        if (sl[7:0] != 8'hFF) cnt++;
        sl = nxt(sl);
      end
      raw += cnt;
      sbus.crossover_gene = {4{$urandom}};
      chk("sat_cnt", 64'(sbus.mutation_count), 64'(cnt));
      chk("sat_tot", 64'(sbus.total_mutations),
          64'((raw > 65535) ? 65535 : raw));
    end
    chk("sat_final", 64'(sbus.total_mutations), 64'hFFFF);
    sbus.in_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    fork
      main_seq();
      sat_seq();
    join
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mutation_engine.md
Name: mutation_engine

Overview:
- Downstream neighbour of the crossover stage in the GA datapath.
- Accepts one crossover child chromosome (NUM_GENES packed GENE_W-bit genes) through a valid/ready handshake.
- Walks the genes one per cycle and flips one LFSR-selected bit in each gene whose random roll falls below a programmable mutation rate.
- Presents the mutated chromosome downstream, toward fitness evaluation and population write-back, through a valid/ready handshake.

Parameters:
GENE_W, 8, bits per gene (power of two, 2..16)
NUM_GENES, 4, genes per chromosome; chromosome width CHROM_W = GENE_W*NUM_GENES
LFSR_SEED, 32'hACE12357, LFSR value after reset and substitute for a zero seed

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous active-low reset
in_valid  in  1  crossover_gene is valid
in_ready  out  1  engine can accept a chromosome
crossover_gene  in  CHROM_W  child chromosome from crossover; gene i = bits [i*GENE_W +: GENE_W]
mutation_rate  in  8  per-gene mutation threshold, sampled at accept
seed_load  in  1  load LFSR from seed (honoured only in IDLE)
seed  in  32  LFSR seed value
out_valid  out  1  mutated_gene is valid
out_ready  in  1  downstream accepts the result
mutated_gene  out  CHROM_W  mutated chromosome
mutation_count  out  $clog2(NUM_GENES+1)  genes mutated in the current result
total_mutations  out  16  saturating count of all mutations since reset

Behaviour:
- One clock; reset is synchronous and active-low.
- While rst=0 at a rising edge:
  - state=IDLE, LFSR=LFSR_SEED.
  - out_valid=0, mutated_gene=0, mutation_count=0, total_mutations=0.
  - in_ready is forced to 0 while rst is low.
- States:
  - IDLE: in_ready = !seed_load.
    - seed_load=1: LFSR <= (seed==0) ? LFSR_SEED : seed; an in_valid in the same cycle is not accepted.
    - Accept on in_valid & in_ready: latch crossover_gene into the work register, latch mutation_rate, idx=0, clear mutation_count, go MUTATE.
  - MUTATE: in_ready=0. Each cycle:
    - LFSR advances one step; L is the value before the step.
    - roll = L[7:0], bitsel = L[8 +: $clog2(GENE_W)].
    - If roll < rate (unsigned), work gene idx ^= (1 << bitsel), mutation_count += 1, and total_mutations += 1, saturating at 16'hFFFF.
    - idx increments; after idx==NUM_GENES-1, go DONE and load mutated_gene from the final work value.
  - DONE: out_valid=1.
    - mutated_gene and mutation_count are held stable until out_valid & out_ready.
    - On that handshake, go IDLE.
    - seed_load is ignored.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1, mask 32'h80200003.
  - Step: L = L[0] ? (L>>1)^mask : L>>1.
  - Advances only in MUTATE; it never reaches zero.
- Latency: out_valid rises exactly NUM_GENES cycles after the accepting edge. Throughput is one chromosome per NUM_GENES+2 cycles with out_ready=1.
- Rate boundaries:
  - rate=0: no gene is mutated.
  - rate=255: a gene mutates unless roll==255.
- Each mutation changes exactly one bit of the gene. A gene is mutated at most once per pass.
- mutation_rate or crossover_gene changes after accept have no effect on the current pass.
- Reset asserted mid-MUTATE or in DONE abandons the pass. On the next cycle after rst returns high: out_valid=0, in_ready=1.

Test Plan:
1. Hold rst=0 for 3 cycles, then release -> during reset out_valid=0, in_ready=0, mutated_gene=0, total_mutations=0; first cycle after release in_ready=1.
2. seed_load with seed=1, then crossover_gene=32'h04030201, rate=0, out_ready=1 -> out_valid exactly 4 cycles after accept, mutated_gene=32'h04030201, mutation_count=0, total_mutations=0.
3. seed=32'h12345678, rate=255, gene=32'h08070605 -> result matches a bit-exact LFSR model. Each byte of (result ^ input) has popcount ≤1, mutation_count equals the number of nonzero bytes, and total_mutations increases by the same amount.
4. Same as 3 with out_ready=0 for 10 cycles after out_valid -> out_valid and mutated_gene stay stable and in_ready=0. A following chromosome's result equals the no-stall run, confirming the LFSR did not advance during the stall.
5. seed_load with seed=0 -> same outputs as after reset. seed_load and in_valid in the same IDLE cycle -> no accept that cycle, accept on the next. Reloading the same seed gives identical results.
6. Pull rst low in the 2nd MUTATE cycle for 1 cycle -> no out_valid for that pass, in_ready=1 afterwards, total_mutations=0. Sixteen-bit saturation: force 70,000 mutations at rate=255 -> total_mutations stays 16'hFFFF.
